// File: rtl/trap_pkg.sv
// trap_pkg: shared types and default sizing for the trap priority controller.
//   trap_state_e          - handshake FSM states (idle, presenting, servicing)
//   TrapNsrcDefault       - default number of trap sources
//   TrapRwDefault         - default reason-code width
//   TrapNestDepthDefault  - default preemption stack depth
package trap_pkg;

  localparam int unsigned TrapNsrcDefault      = 10;
  localparam int unsigned TrapRwDefault        = $clog2(TrapNsrcDefault);
  localparam int unsigned TrapNestDepthDefault = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StSvc  = 2'd2
  } trap_state_e;

endpackage

// File: rtl/trap_prio_enc.sv
// trap_prio_enc: combinational highest-index priority encoder.
// Ports:
//   eff     in  NSRC  eligible (pending and unmasked) sources
//   winner  out RW    index of the highest set bit of eff (0 when none)
//   eff_any out 1     eff is nonzero
module trap_prio_enc #(
  parameter int unsigned NSRC = 10,
  parameter int unsigned RW   = $clog2(NSRC)
) (
  input  logic [NSRC-1:0] eff,
  output logic [RW-1:0]   winner,
  output logic            eff_any
);

  // Ascending scan: the last (highest) set index overwrites earlier ones.
  always_comb begin
    winner = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (eff[i]) winner = RW'(i);
    end
  end

  assign eff_any = |eff;

endmodule

// File: rtl/trap_prio_ctrl.sv
// trap_prio_ctrl: latches per-source trap events, picks the highest-index unmasked
// pending source and runs a present/ack/service handshake with the CPU.
//
// Optional feature: define TRAP_NEST_EN to allow a higher-index source to preempt the
// handler in service. The interrupted reason is pushed on a NEST_DEPTH-deep stack and
// restored when the nested handler signals trap_done. Without the macro there is no
// stack, nest_lvl is tied to 0 and a new source waits for the return to idle.
//
// Ports:
//   clk          in   1      clock, all state on rising edge
//   rst_n        in   1      asynchronous active-low reset
//   src_req      in   NSRC   per-source trap event (pulse or level)
//   src_mask     in   NSRC   1 = source excluded from arbitration (still latched)
//   trap_ack     in   1      CPU accepts the presented trap (only honoured while presenting)
//   trap_done    in   1      CPU finished the current handler (only honoured in service)
//   trap_req     out  1      trap presented to CPU
//   trap_reason  out  RW     index of presented or serviced source
//   trap_busy    out  1      a handler is in service
//   nest_lvl     out  LW     preemption stack occupancy
module trap_prio_ctrl
  import trap_pkg::*;
#(
  parameter int unsigned NSRC       = TrapNsrcDefault,
  parameter int unsigned RW         = $clog2(NSRC),
  parameter int unsigned NEST_DEPTH = TrapNestDepthDefault
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NSRC-1:0]                 src_req,
  input  logic [NSRC-1:0]                 src_mask,
  input  logic                            trap_ack,
  input  logic                            trap_done,
  output logic                            trap_req,
  output logic [RW-1:0]                   trap_reason,
  output logic                            trap_busy,
  output logic [$clog2(NEST_DEPTH+1)-1:0] nest_lvl
);

  localparam int unsigned LW = $clog2(NEST_DEPTH + 1);

  trap_state_e     state_q;
  logic [NSRC-1:0] pend_q, pend_d, pend_clr;
  logic [NSRC-1:0] eff;
  logic [RW-1:0]   winner;
  logic            eff_any;
  logic [RW-1:0]   reason_q;
  logic            req_q;
  logic            busy_q;
  logic            ack_take;

  // Pending latch: a new event in the same cycle as its ack-clear wins.
  assign ack_take = (state_q == StReq) && trap_ack;

  always_comb begin
    pend_clr = '0;
    if (ack_take) pend_clr[reason_q] = 1'b1;
    pend_d = (pend_q & ~pend_clr) | src_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  assign eff = pend_q & ~src_mask;

  trap_prio_enc #(
    .NSRC (NSRC),
    .RW   (RW)
  ) u_enc (
    .eff     (eff),
    .winner  (winner),
    .eff_any (eff_any)
  );

`ifdef TRAP_NEST_EN
  localparam int unsigned SW = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;

  logic [LW-1:0] nest_q;
  logic [RW-1:0] stack_q [NEST_DEPTH];
  logic [SW-1:0] push_idx;
  logic [SW-1:0] pop_idx;
  logic          can_preempt;

  assign push_idx    = nest_q[SW-1:0];
  assign pop_idx     = SW'(nest_q - LW'(1));
  assign can_preempt = eff_any && (winner > reason_q) && (nest_q < LW'(NEST_DEPTH));
  assign nest_lvl    = nest_q;
`else
  assign nest_lvl = '0;
`endif

  // Handshake FSM; all outputs are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      reason_q <= '0;
      req_q    <= 1'b0;
      busy_q   <= 1'b0;
`ifdef TRAP_NEST_EN
      nest_q   <= '0;
      for (int unsigned k = 0; k < NEST_DEPTH; k++) stack_q[k] <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (eff_any) begin
            state_q  <= StReq;
            reason_q <= winner;
            req_q    <= 1'b1;
          end
        end
        StReq: begin
          // Reason is frozen here; later, higher sources wait for the ack.
          if (trap_ack) begin
            state_q <= StSvc;
            req_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        StSvc: begin
`ifdef TRAP_NEST_EN
          // Completion is handled before any preemption decision in the same cycle.
          if (trap_done && (nest_q != '0)) begin
            reason_q <= stack_q[pop_idx];
            nest_q   <= nest_q - LW'(1);
          end else if (trap_done) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (can_preempt) begin
            // Outer handler remains in service, so busy stays high while presenting.
            stack_q[push_idx] <= reason_q;
            nest_q            <= nest_q + LW'(1);
            reason_q          <= winner;
            state_q           <= StReq;
            req_q             <= 1'b1;
          end
`else
          if (trap_done) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
`endif
        end
        default: begin
          state_q <= StIdle;
          req_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign trap_req    = req_q;
  assign trap_reason = reason_q;
  assign trap_busy   = busy_q;

endmodule

// File: tb/tb_trap_prio_ctrl.sv
// Scoreboard bench for trap_prio_ctrl. The driver feeds directed and random stimulus,
// advances a transaction-level model (pending set, offered trap, stack of active
// handlers) and queues the expected status of every cycle plus every new presentation.
// A monitor on the falling edge pops and compares.
module tb_trap_prio_ctrl;

  localparam int NSRC       = 10;
  localparam int RW         = 4;
  localparam int NEST_DEPTH = 4;
  localparam int LW         = 3;
`ifdef TRAP_NEST_EN
  localparam bit Nest = 1'b1;
`else
  localparam bit Nest = 1'b0;
`endif

  logic            clk;
  logic            rst_n;
  logic [NSRC-1:0] src_req;
  logic [NSRC-1:0] src_mask;
  logic            trap_ack;
  logic            trap_done;
  logic            trap_req;
  logic [RW-1:0]   trap_reason;
  logic            trap_busy;
  logic [LW-1:0]   nest_lvl;

  trap_prio_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .src_req     (src_req),
    .src_mask    (src_mask),
    .trap_ack    (trap_ack),
    .trap_done   (trap_done),
    .trap_req    (trap_req),
    .trap_reason (trap_reason),
    .trap_busy   (trap_busy),
    .nest_lvl    (nest_lvl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit req;
    bit busy;
    int reason;
    int nest;
  } st_t;

  st_t sq[$];
  int  pq[$];
  int  checks;
  int  failures;

  // Model state
  bit  m_pend [NSRC];
  int  m_offered;
  int  m_active[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NSRC; i++) m_pend[i] = 1'b0;
    m_offered = -1;
    m_active.delete();
  endtask

  task automatic model_update(input logic [NSRC-1:0] r, input logic [NSRC-1:0] m,
                              input logic a, input logic d);
    int w;
    w = -1;
    for (int i = 0; i < NSRC; i++) if (m_pend[i] && !m[i]) w = i;
    if (m_offered >= 0) begin
      if (a) begin
        m_pend[m_offered] = 1'b0;
        m_active.push_back(m_offered);
        m_offered = -1;
      end
    end else if (m_active.size() > 0) begin
      if (d) void'(m_active.pop_back());
      else if (Nest && w > m_active[m_active.size()-1] && m_active.size() - 1 < NEST_DEPTH)
        m_offered = w;
    end else if (w >= 0) begin
      m_offered = w;
    end
    for (int i = 0; i < NSRC; i++) if (r[i]) m_pend[i] = 1'b1;
  endtask

  task automatic step(input logic [NSRC-1:0] r, input logic [NSRC-1:0] m,
                      input logic a, input logic d);
    int  was;
    st_t st;
    src_req = r; src_mask = m; trap_ack = a; trap_done = d;
    @(posedge clk);
    was = m_offered;
    model_update(r, m, a, d);
    if (m_offered >= 0 && was < 0) pq.push_back(m_offered);
    st.req  = (m_offered >= 0);
    st.busy = (m_active.size() > 0);
    if (m_offered >= 0) st.reason = m_offered;
    else if (m_active.size() > 0) st.reason = m_active[m_active.size()-1];
    else st.reason = 0;
    if (m_offered >= 0) st.nest = m_active.size();
    else st.nest = (m_active.size() > 0) ? m_active.size() - 1 : 0;
    sq.push_back(st);
    #1;
  endtask

  task automatic serve(input int n, input logic [NSRC-1:0] mk);
    for (int k = 0; k < n; k++) begin
      if (m_offered >= 0) step('0, mk, 1'b1, 1'b0);
      else if (m_active.size() > 0) step('0, mk, 1'b0, 1'b1);
      else step('0, mk, 1'b0, 1'b0);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sq.delete();
    pq.delete();
    model_reset();
    src_req = '0; src_mask = '0; trap_ack = 1'b0; trap_done = 1'b0;
    #2;
    chk("rst_trap_req", int'(trap_req), 0);
    chk("rst_trap_busy", int'(trap_busy), 0);
    chk("rst_trap_reason", int'(trap_reason), 0);
    chk("rst_nest_lvl", int'(nest_lvl), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor
  initial begin
    st_t st;
    int  e;
    bit  prev_req;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && sq.size() > 0) begin
        st = sq.pop_front();
        chk("cyc_trap_req", int'(trap_req), int'(st.req));
        chk("cyc_trap_busy", int'(trap_busy), int'(st.busy));
        chk("cyc_nest_lvl", int'(nest_lvl), st.nest);
        if (st.req || st.busy) chk("cyc_trap_reason", int'(trap_reason), st.reason);
        if (trap_req && !prev_req) begin
          if (pq.size() == 0) chk("present_unexpected", int'(trap_reason), -1);
          else begin
            e = pq.pop_front();
            chk("present_reason", int'(trap_reason), e);
          end
        end
      end
      prev_req = trap_req;
    end
  end

  // Driver
  initial begin
    logic [NSRC-1:0] r;
    logic [NSRC-1:0] cur_mask;
    logic            a;
    logic            d;
    checks = 0;
    failures = 0;
    model_reset();
    rst_n = 1'b0;
    src_req = '0; src_mask = '0; trap_ack = 1'b0; trap_done = 1'b0;
    #3;
    chk("init_trap_req", int'(trap_req), 0);
    chk("init_trap_busy", int'(trap_busy), 0);
    chk("init_nest_lvl", int'(nest_lvl), 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Single source, two-cycle latency, ack then done
    step(10'h008, '0, 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    step('0, '0, 1'b1, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b1);
    step('0, '0, 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b0);

    // Two sources together: 9 first, then 2
    step(10'h204, '0, 1'b0, 1'b0);
    serve(12, '0);

    // Masked source waits, then wins when the mask drops
    step(10'h020, 10'h020, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) step('0, 10'h020, 1'b0, 1'b0);
    serve(8, '0);

    // Higher source arrives while servicing reason 1
    step(10'h002, '0, 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    step('0, '0, 1'b1, 1'b0);
    step(10'h080, '0, 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    serve(12, '0);

    // Stray ack/done while idle are ignored
    step('0, '0, 1'b1, 1'b1);
    step('0, '0, 1'b1, 1'b1);

    // Reset while presenting with two pending events
    step(10'h204, '0, 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    do_reset();
    for (int k = 0; k < 5; k++) step('0, '0, 1'b0, 1'b0);

    // Random traffic
    cur_mask = '0;
    for (int c = 0; c < 3000; c++) begin
      r = '0;
      for (int i = 0; i < NSRC; i++) if ($urandom_range(0, 15) == 0) r[i] = 1'b1;
      if ($urandom_range(0, 7) == 0) cur_mask = NSRC'($urandom) & NSRC'($urandom);
      a = ($urandom_range(0, 2) == 0);
      d = ($urandom_range(0, 3) == 0);
      step(r, cur_mask, a, d);
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    step('0, '0, 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    chk("present_leftover", pq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
